// File: rtl/hilo_muldiv_unit_if.sv
// Bundle between the control/writeback side and the HI/LO multiply-divide engine.
// The master issues operations and MFHI/MFLO reads; the slave is the engine.
interface hilo_muldiv_unit_if;
    logic        START;
    logic [11:0] HILO_control;
    logic [31:0] IN_MD_1;
    logic [31:0] IN_MD_2;
    logic [31:0] OUT_HILO32;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        BUSY;
    logic        DONE;
    logic        STALL;

    modport master (
        output START, HILO_control, IN_MD_1, IN_MD_2,
        input  OUT_HILO32, HI, LO, BUSY, DONE, STALL
    );

    modport slave (
        input  START, HILO_control, IN_MD_1, IN_MD_2,
        output OUT_HILO32, HI, LO, BUSY, DONE, STALL
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Sequential signed MULT/DIV engine owning HI/LO: 32 iterations on operand
// magnitudes, then one FIX cycle that applies signs and writes HI/LO.
module hilo_muldiv_unit (
    input  logic                     clk,
    input  logic                     rst,
    hilo_muldiv_unit_if.slave        bus
);
    localparam logic [11:0] OP_MULT = 12'b000011011000;
    localparam logic [11:0] OP_DIV  = 12'b000011011010;
    localparam logic [11:0] OP_MFHI = 12'b000011010000;
    localparam logic [11:0] OP_MFLO = 12'b000011010010;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        sign_a_q, sign_b_q, is_div_q;
    logic [31:0] mag_a_q, mag_b_q;
    logic [63:0] acc_q;
    logic [32:0] rem_q;
    logic [31:0] hi_q, lo_q;
    logic        busy_q, done_q;

    logic        is_mfhi, is_mflo;
    logic [31:0] mag_a_d, mag_b_d;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_d;
    logic [32:0] rem_shift, rem_diff, rem_d;
    logic [31:0] quo_d;
    logic [63:0] prod_signed;
    logic [31:0] fix_hi_d, fix_lo_d;

    assign is_mfhi = (bus.HILO_control == OP_MFHI);
    assign is_mflo = (bus.HILO_control == OP_MFLO);
    assign mag_a_d = bus.IN_MD_1[31] ? (~bus.IN_MD_1 + 32'd1) : bus.IN_MD_1;
    assign mag_b_d = bus.IN_MD_2[31] ? (~bus.IN_MD_2 + 32'd1) : bus.IN_MD_2;

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_a_q} : 33'd0);
    assign mul_acc_d = {mul_sum, acc_q[31:1]};

    // Divide: acc[31:0] shifts dividend bits out at the top and quotient bits in at the bottom.
    assign rem_shift = {rem_q[31:0], acc_q[31]};
    assign rem_diff  = rem_shift - {1'b0, mag_b_q};
    assign rem_d     = rem_diff[32] ? rem_shift : rem_diff;
    assign quo_d     = {acc_q[30:0], ~rem_diff[32]};

    assign prod_signed = (sign_a_q ^ sign_b_q) ? (~acc_q + 64'd1) : acc_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fix_hi_d = prod_signed[63:32];
        fix_lo_d = prod_signed[31:0];
        if (is_div_q) begin
            fix_hi_d = sign_a_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
            fix_lo_d = (sign_a_q ^ sign_b_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
            // Zero divisor yields an all-ones quotient; HI already equals the dividend.
            if (mag_b_q == 32'd0) fix_lo_d = 32'hFFFF_FFFF;
        end
    end

    always_comb begin
        bus.OUT_HILO32 = 32'd0;
        if (is_mfhi)      bus.OUT_HILO32 = hi_q;
        else if (is_mflo) bus.OUT_HILO32 = lo_q;
    end

    assign bus.STALL = busy_q & (is_mfhi | is_mflo | bus.START);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            mag_a_q  <= 32'd0;
            mag_b_q  <= 32'd0;
            acc_q    <= 64'd0;
            rem_q    <= 33'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.START && (bus.HILO_control == OP_MULT ||
                                      bus.HILO_control == OP_DIV)) begin
                        is_div_q <= (bus.HILO_control == OP_DIV);
                        state_q  <= (bus.HILO_control == OP_DIV) ? DIV : MUL;
                        sign_a_q <= bus.IN_MD_1[31];
                        sign_b_q <= bus.IN_MD_2[31];
                        mag_a_q  <= mag_a_d;
                        mag_b_q  <= mag_b_d;
                        acc_q    <= (bus.HILO_control == OP_DIV) ? {32'd0, mag_a_d}
                                                                 : {32'd0, mag_b_d};
                        rem_q    <= 33'd0;
                        cnt_q    <= 6'd0;
                        busy_q   <= 1'b1;
                    end
                end
                MUL: begin
                    acc_q <= mul_acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                DIV: begin
                    rem_q <= rem_d;
                    acc_q <= {32'd0, quo_d};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= fix_hi_d;
                    lo_q    <= fix_lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed test-plan vectors, random
// MULT/DIV against a plain-arithmetic model, hazard/stall and mid-op reset.
module tb_hilo_muldiv_unit;
    localparam logic [11:0] OP_MULT = 12'b000011011000;
    localparam logic [11:0] OP_DIV  = 12'b000011011010;
    localparam logic [11:0] OP_MFHI = 12'b000011010000;
    localparam logic [11:0] OP_MFLO = 12'b000011010010;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;

    hilo_muldiv_unit_if bus ();
    hilo_muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference result {HI, LO} from signed arithmetic on 64-bit integers.
    function automatic logic [63:0] ref_model(input logic [11:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (op == OP_MULT) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one op on the next negedge and wait for DONE; checks latency and result.
    task automatic run_op(input string tag, input logic [11:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int lat;
        exp = ref_model(op, a, b);
        @(negedge clk);
        bus.START = 1'b1; bus.HILO_control = op; bus.IN_MD_1 = a; bus.IN_MD_2 = b;
        @(posedge clk); #1;
        check({tag, " busy_after_accept"}, 64'(bus.BUSY), 64'd1);
        @(negedge clk);
        bus.START = 1'b0; bus.IN_MD_1 = $urandom; bus.IN_MD_2 = $urandom;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            lat = c;
            if (c == 16) check({tag, " hilo_held"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
            if (bus.DONE) break;
        end
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " hilo"}, {bus.HI, bus.LO}, exp);
        check({tag, " busy_at_done"}, 64'(bus.BUSY), 64'd0);
        exp_hi = exp[63:32];
        exp_lo = exp[31:0];
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [11:0] rop;
        int done_cnt;
        bit seen;

        bus.START = 1'b0; bus.HILO_control = OP_MFHI;
        bus.IN_MD_1 = 32'd0; bus.IN_MD_2 = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {bus.HI, bus.LO}, 64'd0);
        check("reset_busy_done", {62'd0, bus.BUSY, bus.DONE}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_out_stall", {31'd0, bus.STALL, bus.OUT_HILO32}, 64'd0);

        run_op("mult_7_m3", OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
        check("mult_7_m3_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        check("mult_min_min_const", {bus.HI, bus.LO}, 64'h4000_0000_0000_0000);
        run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        check("div_m7_2_const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_5_0", OP_DIV, 32'h0000_0005, 32'h0000_0000);
        check("div_5_0_const", {bus.HI, bus.LO}, 64'h0000_0005_FFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_const", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);
        run_op("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'h0000_0000);

        for (int i = 0; i < 12; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? OP_MULT : OP_DIV;
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 20) * (($urandom_range(0, 1) == 0) ? 1 : -1);
                2: ra = $urandom_range(0, 1000);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        // Hazard: MFHI during MULT 3x4, ignored DIV START, MFLO in the DONE cycle.
        @(negedge clk);
        bus.START = 1'b1; bus.HILO_control = OP_MULT; bus.IN_MD_1 = 32'd3; bus.IN_MD_2 = 32'd4;
        @(posedge clk); #1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        bus.HILO_control = OP_MFHI; #1;
        check("hz_mfhi_stall", 64'(bus.STALL), 64'd1);
        check("hz_mfhi_stale", 64'(bus.OUT_HILO32), 64'(exp_hi));
        @(negedge clk);
        bus.START = 1'b1; bus.HILO_control = OP_DIV;
        bus.IN_MD_1 = 32'd100; bus.IN_MD_2 = 32'd7; #1;
        check("hz_start_stall", 64'(bus.STALL), 64'd1);
        @(negedge clk);
        bus.START = 1'b0; bus.HILO_control = OP_MFHI;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.DONE) begin seen = 1'b1; break; end
        end
        check("hz_done_seen", 64'(seen), 64'd1);
        @(negedge clk);
        bus.HILO_control = OP_MFLO; #1;
        check("hz_mflo_new", {31'd0, bus.STALL, bus.OUT_HILO32}, 64'h0000_000C);
        check("hz_hilo", {bus.HI, bus.LO}, 64'h0000_0000_0000_000C);
        @(posedge clk); #1;
        check("hz_div_ignored", 64'(bus.BUSY), 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd12;

        // Abort: reset at E10 of a new op.
        @(negedge clk);
        bus.START = 1'b1; bus.HILO_control = OP_MULT;
        bus.IN_MD_1 = 32'h1234_5678; bus.IN_MD_2 = 32'h0000_0FFF;
        @(posedge clk); #1;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_hilo", {bus.HI, bus.LO}, 64'd0);
        check("abort_busy", 64'(bus.BUSY), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.DONE) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        exp_hi = 32'd0; exp_lo = 32'd0;
        run_op("after_abort", OP_DIV, 32'd1000, 32'hFFFF_FFF9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
